pwl_delay_sched: RTL and testbench
==================================

Name: pwl_delay_sched

Overview:
- Clocked scheduler that shares one fixed-latency PWL delay path among N_REQ requesters.
- Each requester offers a PWL sample (offset a, slope b) through a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The granted sample is queued with a release timestamp and emitted, scaled, exactly DELAY_CYC clock cycles later.
- Sits between per-lane PWL producers and a single shared downstream PWL consumer.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DEPTH, 8, entries in the scheduling queue (power of 2, 2..64)
- DELAY_CYC, 16, delay from acceptance to release in clk cycles (1..2^CW-1)
- CW, 8, width of the free-running tick counter and of the stored release stamps
- SCALE, 1.0, real gain applied to a and b on release

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester sample valid
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- req_in  input  pwl[N_REQ]  per-requester PWL sample (a, b, t0; t0 is ignored)
- out  output  pwl  released sample
- out_valid  output  1  one-cycle pulse when out is updated
- out_id  output  $clog2(N_REQ)  requester index of the released sample
- occupancy  output  $clog2(DEPTH)+1  queue entries in use
- full  output  1  occupancy==DEPTH

Behaviour:
- Reset (synchronous, rst high at an edge):
  - tick=0, rr_ptr=0, queue emptied, occupancy=0.
  - out_valid=0, out_id=0, out={a:0,b:0,t0:0}.
  - req_ready is held 0 while rst is high.
  - Reset mid-operation discards every queued entry; nothing queued before reset is ever released.
- Tick counter: CW bits, increments every cycle, wraps 2^CW-1 -> 0.
- Arbiter:
  - Combinational round-robin. Search starts at rr_ptr; the first index with req_valid=1 gets the grant.
  - req_ready[g]=1 only if the queue can accept: !full, or full and a pop occurs this cycle.
  - Accept happens when req_valid[g] & req_ready[g] at an edge. On accept, rr_ptr <= (g+1) mod N_REQ; otherwise rr_ptr holds.
  - At most one accept per cycle.
- Push: store {a, b, id=g, rel=tick+DELAY_CYC mod 2^CW} at the tail.
- Pop: when the queue is non-empty and head.rel==tick, the head is popped at that edge. The same edge updates:
  - out.a <= SCALE*head.a
  - out.b <= SCALE*head.b
  - out.t0 <= $realtime
  - out_id <= head.id
  - out_valid <= 1
  - out_valid is 0 in every cycle without a pop. out and out_id hold their values between pops.
- Ordering: DELAY_CYC is constant, so release order equals accept order and only the head is ever compared.
- Latency: a sample accepted at edge k is released at edge k+DELAY_CYC (out_valid high in the following cycle).
- Wrap: equality compare of CW-bit stamps is exact because DELAY_CYC < 2^CW and no entry waits longer than DELAY_CYC.
- Simultaneous push and pop: both occur and occupancy is unchanged. A push to a full queue is legal only in this case.
- Throughput: full rate needs DEPTH >= DELAY_CYC. Otherwise full asserts and req_ready backpressures. Nothing is ever dropped.
- Elaboration check: $fatal if DELAY_CYC<1, DELAY_CYC>=2^CW, or DEPTH is not a power of 2.

Decomposition:
- Shared package pwl_sched_pkg holds:
  - typedef sched_entry_t {real a; real b; logic [IDW-1:0] id; logic [CW-1:0] rel;}
  - function rr_pick(valid, ptr) returning the grant index.
  - the elaboration-check macro.
- One sub-module: pwl_sched_fifo, a DEPTH-entry circular buffer of sched_entry_t with push/pop/head/occupancy/full and pointer wrap.
- Arbiter, tick counter and output register stay in the top module.

Test Plan:
- Single-lane latency: DELAY_CYC=16, rst released. req_valid[2]=1 for one cycle with a=0.5, b=2.0e9, accepted at edge 10 -> out_valid pulses after edge 26, out.a=0.5, out.b=2.0e9 (SCALE=1), out_id=2.
- Round-robin: all four req_valid held high for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 and releases in the same order DELAY_CYC later. SCALE=2.0 doubles a and b.
- Backpressure: DEPTH=4, DELAY_CYC=10, lane 0 held valid -> 4 accepts, then full=1 and req_ready=0 until the first pop at edge +10. An accept and a pop then occur in the same cycle; occupancy stays 4.
- Tick wrap: CW=4, DELAY_CYC=6, accept when tick=13 -> rel=3, released exactly 6 cycles later.
- Reset mid-flight: 3 entries queued, rst pulsed for 1 cycle -> occupancy=0 and out_valid stays 0 for the next 2*DELAY_CYC cycles. A new accept is then released normally.
- No spurious release: queue empty for 40 cycles through a tick wrap -> out_valid never asserts.

Source files
------------

// File: rtl/pwl_sched_pkg.sv
// Shared types and helpers for the PWL delay scheduler.
//
// Contents:
//   pwl_t          PWL sample {a, b, t0} as carried on the requester and output buses
//   sched_entry_t  queued sample {a, b, id, rel}. The id and release-stamp fields are sized for the
//                  largest legal configuration. Narrower configurations zero-extend into them.
//   rr_pick        round-robin grant search over a zero-extended valid vector
//   PWL_SCHED_ELAB_CHECK  elaboration-time parameter guard (generate-if with $fatal)

`define PWL_SCHED_ELAB_CHECK(NR, DP, DC, WC) if ((NR) < 2 || (NR) > 16 || (DP) < 2 || (DP) > 64 || ((DP) & ((DP) - 1)) != 0 || (WC) < 1 || (WC) > 31 || (DC) < 1 || (DC) >= (1 << (WC))) begin : g_param_check $fatal(1, "pwl_delay_sched: illegal N_REQ/DEPTH/DELAY_CYC/CW"); end

package pwl_sched_pkg;

    localparam int N_REQ_MAX   = 16;
    localparam int ID_MAX_W    = 4;
    localparam int STAMP_MAX_W = 32;

    typedef struct {
        real a;
        real b;
        real t0;
    } pwl_t;

    typedef struct {
        real                    a;
        real                    b;
        logic [ID_MAX_W-1:0]    id;
        logic [STAMP_MAX_W-1:0] rel;
    } sched_entry_t;

    // The search wraps modulo N_REQ_MAX rather than modulo N_REQ. Unused lanes are always zero in
    // the extended valid vector, so the first hit after ptr is the same either way.
    // The loop runs backwards, so the smallest offset from ptr wins.
    function automatic logic [ID_MAX_W-1:0] rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                                    input logic [ID_MAX_W-1:0]  ptr);
        logic [ID_MAX_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ_MAX - 1; i >= 0; i--) begin
            idx = ptr + ID_MAX_W'(i);
            if (valid[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/pwl_delay_sched_if.sv
// Bus bundle for the PWL delay scheduler.
//
// Signals:
//   req_valid [N_REQ]  per-requester sample valid
//   req_ready [N_REQ]  per-requester accept, one-hot or zero
//   req_in    [N_REQ]  per-requester PWL sample (t0 ignored)
//   out                released, scaled sample
//   out_valid          one-cycle pulse when out is updated
//   out_id             requester index of the released sample
//   occupancy          queue entries in use
//   full               occupancy == DEPTH
//
// Modports:
//   master  the producer / consumer side
//   slave   the scheduler

interface pwl_delay_sched_if
    import pwl_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DEPTH = 8
);

    localparam int IDW = $clog2(N_REQ);
    localparam int OCW = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    pwl_t             req_in [N_REQ];
    pwl_t             out;
    logic             out_valid;
    logic [IDW-1:0]   out_id;
    logic [OCW-1:0]   occupancy;
    logic             full;

    modport master (
        output req_valid, req_in,
        input  req_ready, out, out_valid, out_id, occupancy, full
    );

    modport slave (
        input  req_valid, req_in,
        output req_ready, out, out_valid, out_id, occupancy, full
    );

endinterface

// File: rtl/pwl_sched_fifo.sv
// Circular buffer of scheduler entries.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset (reset empties the buffer)
//   push        write push_data at the tail; honoured when not full, or when full with a pop
//   pop         retire the head; ignored when empty
//   push_data   entry to enqueue
//   head        current head entry (valid when !empty)
//   occupancy   entries in use, 0..DEPTH
//   full, empty occupancy flags

module pwl_sched_fifo
    import pwl_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  sched_entry_t           push_data,
    output sched_entry_t           head,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    sched_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    // A full buffer still takes a push when the head leaves in the same cycle. The write lands in
    // the slot being vacated.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage needs no reset. An entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign occupancy = count;
    assign full      = (count == (AW + 1)'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/pwl_delay_sched.sv
// Shares one fixed-latency PWL delay path among N_REQ requesters.
// A round-robin arbiter accepts at most one sample per cycle and stamps it with tick+DELAY_CYC.
// The sample is queued, then released scaled by SCALE exactly DELAY_CYC cycles after acceptance.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   pwl_delay_sched_if slave. It carries req_valid/req_ready/req_in from the producers and
//         out/out_valid/out_id/occupancy/full to the consumer.

module pwl_delay_sched
    import pwl_sched_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  DEPTH     = 8,
    parameter int  DELAY_CYC = 16,
    parameter int  CW        = 8,
    parameter real SCALE     = 1.0
) (
    input logic                clk,
    input logic                rst,
    pwl_delay_sched_if.slave   bus
);

    localparam int IDW = $clog2(N_REQ);
    localparam int OCW = $clog2(DEPTH) + 1;

    `PWL_SCHED_ELAB_CHECK(N_REQ, DEPTH, DELAY_CYC, CW)

    logic [CW-1:0]        tick;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant;
    logic [N_REQ_MAX-1:0] valid_ext;
    logic [N_REQ-1:0]     ready;
    logic [CW-1:0]        rel_stamp;
    logic                 any_valid;
    logic                 can_accept;
    logic                 accept;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OCW-1:0]       fifo_occ;
    sched_entry_t         head;
    sched_entry_t         push_entry;
    pwl_t                 out_reg;
    logic                 out_valid_reg;
    logic [IDW-1:0]       out_id_reg;

    // Every entry waits exactly DELAY_CYC < 2^CW cycles, so comparing only the head stamp against
    // the wrapping tick is exact.
    // A pop frees a slot in the same cycle, so a full queue can still accept when its head is
    // leaving.
    always_comb begin
        valid_ext             = '0;
        valid_ext[N_REQ-1:0]  = bus.req_valid;
        grant                 = IDW'(rr_pick(valid_ext, ID_MAX_W'(rr_ptr)));
        any_valid             = |bus.req_valid;
        pop                   = !fifo_empty && (head.rel == STAMP_MAX_W'(tick));
        can_accept            = !fifo_full || pop;
        accept                = !rst && any_valid && can_accept;
        ready                 = '0;
        if (accept) begin
            ready[grant] = 1'b1;
        end
        rel_stamp     = tick + CW'(DELAY_CYC);
        push_entry.a  = bus.req_in[grant].a;
        push_entry.b  = bus.req_in[grant].b;
        push_entry.id = ID_MAX_W'(grant);
        push_entry.rel = STAMP_MAX_W'(rel_stamp);
    end

    pwl_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head),
        .occupancy (fifo_occ),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The tick counter and the round-robin pointer live here.
    // The pointer moves past the winner only on an accept.
    // The output register updates only on a pop. out_valid is the pop pulse delayed by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick          <= '0;
            rr_ptr        <= '0;
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_reg.a     <= 0.0;
            out_reg.b     <= 0.0;
            out_reg.t0    <= 0.0;
        end else begin
            tick          <= tick + 1'b1;
            out_valid_reg <= pop;
            if (accept) begin
                rr_ptr <= (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                out_reg.a  <= SCALE * head.a;
                out_reg.b  <= SCALE * head.b;
                out_reg.t0 <= $realtime;
                out_id_reg <= IDW'(head.id);
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_id    = out_id_reg;
    assign bus.occupancy = fifo_occ;
    assign bus.full      = fifo_full;

endmodule

// File: tb/tb_pwl_delay_sched.sv
// Directed testbench for pwl_delay_sched.
// The configuration is small: DEPTH=4, DELAY_CYC=10, CW=4, SCALE=2.0.
// Backpressure and tick wrap therefore show up within a few dozen cycles.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at the same point,
// i.e. after the edge has settled.

module tb_pwl_delay_sched;
    import pwl_sched_pkg::*;

    localparam int  NR   = 4;
    localparam int  DP   = 4;
    localparam int  DLY  = 10;
    localparam int  TW   = 4;
    localparam real GAIN = 2.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectorCount = 0;
    int   missCount   = 0;

    pwl_delay_sched_if #(.N_REQ(NR), .DEPTH(DP)) bus ();

    pwl_delay_sched #(
        .N_REQ     (NR),
        .DEPTH     (DP),
        .DELAY_CYC (DLY),
        .CW        (TW),
        .SCALE     (GAIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input real observed, input real expected);
        vectorCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %g, expected %g", tag, observed, expected);
        end
    endtask

    // Drive the valid pattern, check the combinational ready just before the edge, then clock.
    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR-1:0] expReady,
                                 input string tag);
        bus.req_valid = valid;
        #2;
        checkOutput(tag, real'(bus.req_ready), real'(expReady));
        @(posedge clk);
        #1;
    endtask

    task automatic setLane(input int lane, input real a, input real b);
        bus.req_in[lane].a  = a;
        bus.req_in[lane].b  = b;
        bus.req_in[lane].t0 = 0.0;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] expReady;
        int            id;

        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            setLane(i, 0.0, 0.0);
        end
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Reset state
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_id", bus.out_id, 0);
        checkOutput("rst_out_a", bus.out.a, 0.0);
        checkOutput("rst_out_b", bus.out.b, 0.0);
        checkOutput("rst_occ", bus.occupancy, 0);
        checkOutput("rst_full", bus.full, 0);

        // Single lane latency: lane 2 accepted once, released DLY edges later and scaled
        setLane(2, 0.5, 2.0e9);
        applyStimulus(4'b0100, 4'b0100, "t1_accept_ready");
        checkOutput("t1_occ", bus.occupancy, 1);
        for (int k = 1; k < DLY; k++) begin
            applyStimulus('0, '0, "t1_idle_ready");
            checkOutput("t1_no_early", bus.out_valid, 0);
        end
        applyStimulus('0, '0, "t1_idle_ready");
        checkOutput("t1_out_valid", bus.out_valid, 1);
        checkOutput("t1_out_id", bus.out_id, 2);
        checkOutput("t1_out_a", bus.out.a, 1.0);
        checkOutput("t1_out_b", bus.out.b, 4.0e9);
        checkOutput("t1_occ_after", bus.occupancy, 0);
        applyStimulus('0, '0, "t1_idle_ready");
        checkOutput("t1_pulse_end", bus.out_valid, 0);
        checkOutput("t1_hold_a", bus.out.a, 1.0);
        checkOutput("t1_hold_id", bus.out_id, 2);

        // Round robin with all lanes valid
        // 4 accepts fill the queue, ready is 0 until the first pop at +DLY
        // From then on each pop admits the next lane and occupancy stays at DEPTH
        doReset();
        for (int i = 0; i < NR; i++) begin
            setLane(i, real'(i + 1), real'(i + 1) * 1.0e6);
        end
        for (int n = 0; n < 14; n++) begin
            if (n < 4) begin
                expReady = 4'(1 << n);
            end else if (n < 10) begin
                expReady = '0;
            end else begin
                expReady = 4'(1 << (n - 10));
            end
            applyStimulus(4'hF, expReady, "t2_ready");
            checkOutput("t2_out_valid", bus.out_valid, (n >= 10) ? 1 : 0);
            checkOutput("t2_occ", bus.occupancy, (n < 4) ? n + 1 : 4);
            checkOutput("t2_full", bus.full, (n >= 3) ? 1 : 0);
            if (n >= 10) begin
                id = n - 10;
                checkOutput("t2_out_id", bus.out_id, id);
                checkOutput("t2_out_a", bus.out.a, GAIN * real'(id + 1));
                checkOutput("t2_out_b", bus.out.b, GAIN * real'(id + 1) * 1.0e6);
            end
        end
        for (int n = 14; n < 24; n++) begin
            applyStimulus('0, '0, "t2_drain_ready");
            checkOutput("t2_drain_valid", bus.out_valid, (n >= 20) ? 1 : 0);
            checkOutput("t2_drain_occ", bus.occupancy, (n < 20) ? 4 : 23 - n);
            checkOutput("t2_drain_full", bus.full, (n < 20) ? 1 : 0);
            if (n >= 20) begin
                id = n - 20;
                checkOutput("t2_drain_id", bus.out_id, id);
                checkOutput("t2_drain_a", bus.out.a, GAIN * real'(id + 1));
            end
        end

        // Tick wrap: accept with tick=13, so the stamp wraps to 7 and release is still +DLY
        doReset();
        for (int k = 0; k < 13; k++) begin
            applyStimulus('0, '0, "t3_idle_ready");
            checkOutput("t3_quiet", bus.out_valid, 0);
        end
        setLane(3, -1.25, 3.0e8);
        applyStimulus(4'b1000, 4'b1000, "t3_accept_ready");
        for (int k = 1; k < DLY; k++) begin
            applyStimulus('0, '0, "t3_idle_ready");
            checkOutput("t3_no_early", bus.out_valid, 0);
        end
        applyStimulus('0, '0, "t3_idle_ready");
        checkOutput("t3_out_valid", bus.out_valid, 1);
        checkOutput("t3_out_id", bus.out_id, 3);
        checkOutput("t3_out_a", bus.out.a, -2.5);
        checkOutput("t3_out_b", bus.out.b, 6.0e8);

        // Reset mid-flight: the three queued entries must never come out
        setLane(1, 0.75, 1.0e3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, 4'b0010, "t4_fill_ready");
        end
        checkOutput("t4_occ_filled", bus.occupancy, 3);
        rst           = 1'b1;
        bus.req_valid = 4'b0010;
        #2;
        checkOutput("t4_ready_in_rst", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = '0;
        checkOutput("t4_occ_cleared", bus.occupancy, 0);
        checkOutput("t4_out_id_cleared", bus.out_id, 0);
        checkOutput("t4_out_a_cleared", bus.out.a, 0.0);
        for (int k = 0; k < 2 * DLY; k++) begin
            applyStimulus('0, '0, "t4_idle_ready");
            checkOutput("t4_no_stale", bus.out_valid, 0);
        end
        setLane(0, 3.0, -5.0e5);
        applyStimulus(4'b0001, 4'b0001, "t4_accept_ready");
        for (int k = 1; k < DLY; k++) begin
            applyStimulus('0, '0, "t4_idle_ready");
            checkOutput("t4_no_early", bus.out_valid, 0);
        end
        applyStimulus('0, '0, "t4_idle_ready");
        checkOutput("t4_out_valid", bus.out_valid, 1);
        checkOutput("t4_out_id", bus.out_id, 0);
        checkOutput("t4_out_a", bus.out.a, 6.0);
        checkOutput("t4_out_b", bus.out.b, -1.0e6);

        // Empty queue through several tick wraps: no spurious releases
        for (int k = 0; k < 40; k++) begin
            applyStimulus('0, '0, "t5_idle_ready");
            checkOutput("t5_no_release", bus.out_valid, 0);
        end
        checkOutput("t5_hold_a", bus.out.a, 6.0);
        checkOutput("t5_occ", bus.occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
